// File: rtl/event_read_sched.sv
// event_read_sched
//   Drains 64-bit events from the event FIFO onto the host UART link.
//   A START byte from the host begins a run. Each event is popped once and
//   sent MSB byte first. The run ends when the FIFO is empty, a STOP byte
//   arrives, or MAX_EVENTS have been sent. A START that finds the FIFO empty
//   sends a single EMPTY_MARK byte.
//
//   Optional feature (macro EVT_CHECKSUM_EN): each event frame ends with one
//   extra byte, the XOR of all event bytes.
//
// Ports
//   clk, reset     system clock; synchronous active-high reset
//   rx_data_i      command byte from the UART RX
//   rx_valid_i     one-cycle strobe qualifying rx_data_i
//   fifo_dout_i    FIFO read data, valid the cycle after fifo_rd_en_o
//   fifo_empty_i   FIFO empty flag
//   fifo_rd_en_o   FIFO pop strobe (one cycle per event)
//   tx_data_o      byte to the UART TX
//   tx_valid_o     tx_data_o valid
//   tx_ready_i     UART TX accepts the byte
//   busy_o         high whenever the controller is not idle
//   events_sent_o  events fully sent since the last START (saturating)
//
// Handshake: a TX byte transfers on every rising edge where tx_valid_o and
// tx_ready_i are both high. While tx_valid_o is high and tx_ready_i is low,
// tx_data_o holds its value and tx_valid_o stays high.
//
// All outputs are registered. They are loaded from the next-state value so
// each output lines up with the state it belongs to.
module event_read_sched #(
   parameter int         DATA_W     = 64,
   parameter int         CNT_W      = 16,
   parameter int         MAX_EVENTS = 0,
   parameter logic [7:0] CMD_START  = 8'h73,
   parameter logic [7:0] CMD_STOP   = 8'h6B,
   parameter logic [7:0] EMPTY_MARK = 8'h45
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_valid_i,
   input  logic [DATA_W-1:0] fifo_dout_i,
   input  logic              fifo_empty_i,
   output logic              fifo_rd_en_o,
   output logic [7:0]        tx_data_o,
   output logic              tx_valid_o,
   input  logic              tx_ready_i,
   output logic              busy_o,
   output logic [CNT_W-1:0]  events_sent_o
);

   localparam int                BYTES    = DATA_W / 8;
   localparam int                IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES - 1);
   // Value events_sent_o holds when the event now finishing is the last one
   // allowed by MAX_EVENTS. Only used when MAX_EVENTS is non-zero.
   localparam logic [CNT_W-1:0]  LIMIT_M1 = CNT_W'(MAX_EVENTS - 1);

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LOAD,
      SEND,
      NEXT,
`ifdef EVT_CHECKSUM_EN
      CSUM,
`endif
      MARK
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_shift;
   logic [IDX_W-1:0]  byte_idx;
   logic              stop_pending;
`ifdef EVT_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   logic start_cmd, stop_cmd, tx_fire, last_byte, limit_hit, run_end;

   assign start_cmd   = rx_valid_i && (rx_data_i == CMD_START);
   // STOP only matters during a run; in IDLE it is dropped.
   assign stop_cmd    = rx_valid_i && (rx_data_i == CMD_STOP) && (state_q != IDLE);
   assign tx_fire     = tx_valid_o && tx_ready_i;
   assign last_byte   = (byte_idx == LAST_IDX);
   assign limit_hit   = (MAX_EVENTS != 0) && (events_sent_o == LIMIT_M1);
   // A STOP arriving in the NEXT cycle itself still ends the run.
   assign run_end     = stop_pending || stop_cmd || fifo_empty_i || limit_hit;
   assign shreg_shift = shreg << 8;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start_cmd) state_d = fifo_empty_i ? MARK : POP;
         POP:  state_d = LOAD;
         LOAD: state_d = SEND;
         SEND: begin
            if (tx_fire && last_byte) begin
`ifdef EVT_CHECKSUM_EN
               state_d = CSUM;
`else
               state_d = NEXT;
`endif
            end
         end
`ifdef EVT_CHECKSUM_EN
         CSUM: if (tx_fire) state_d = NEXT;
`endif
         NEXT: state_d = run_end ? IDLE : POP;
         MARK: if (tx_fire) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         fifo_rd_en_o  <= 1'b0;
         tx_valid_o    <= 1'b0;
         tx_data_o     <= 8'h00;
         busy_o        <= 1'b0;
         events_sent_o <= '0;
         stop_pending  <= 1'b0;
         shreg         <= '0;
         byte_idx      <= '0;
`ifdef EVT_CHECKSUM_EN
         csum          <= 8'h00;
`endif
      end else begin
         state_q      <= state_d;
         fifo_rd_en_o <= (state_d == POP);
         busy_o       <= (state_d != IDLE);
`ifdef EVT_CHECKSUM_EN
         tx_valid_o   <= (state_d == SEND) || (state_d == CSUM) || (state_d == MARK);
`else
         tx_valid_o   <= (state_d == SEND) || (state_d == MARK);
`endif
         if (stop_cmd) stop_pending <= 1'b1;

         case (state_q)
            IDLE: begin
               if (start_cmd) begin
                  events_sent_o <= '0;
                  stop_pending  <= 1'b0;
                  if (fifo_empty_i) tx_data_o <= EMPTY_MARK;
               end
            end
            LOAD: begin
               shreg     <= fifo_dout_i;
               byte_idx  <= '0;
               tx_data_o <= fifo_dout_i[DATA_W-1 -: 8];
`ifdef EVT_CHECKSUM_EN
               csum      <= 8'h00;
`endif
            end
            SEND: begin
               if (tx_fire) begin
                  shreg    <= shreg_shift;
                  byte_idx <= byte_idx + IDX_W'(1);
`ifdef EVT_CHECKSUM_EN
                  csum     <= csum ^ tx_data_o;
                  // The checksum byte includes the byte being accepted now.
                  if (last_byte) tx_data_o <= csum ^ tx_data_o;
                  else           tx_data_o <= shreg_shift[DATA_W-1 -: 8];
`else
                  if (last_byte) tx_data_o <= 8'h00;
                  else           tx_data_o <= shreg_shift[DATA_W-1 -: 8];
`endif
               end
            end
`ifdef EVT_CHECKSUM_EN
            CSUM: if (tx_fire) tx_data_o <= 8'h00;
`endif
            NEXT: begin
               if (events_sent_o != '1) events_sent_o <= events_sent_o + CNT_W'(1);
            end
            MARK: if (tx_fire) tx_data_o <= 8'h00;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/event_read_sched.md
Name: event_read_sched

Overview:
- Controller that sequences event readout from the event FIFO to the host UART link.
- Decodes host command bytes from UART RX. On START it pops 64-bit events from the FIFO one at a time and serializes each one MSB-byte-first onto UART TX with a valid/ready handshake.
- Continues until the FIFO is empty, a STOP arrives, or MAX_EVENTS is reached.
- Sits between the UART core and the event FIFO; it replaces host-paced half-word reads.

Parameters:
- DATA_W, 64, event width in bits; multiple of 8.
- CNT_W, 16, width of events_sent_o.
- MAX_EVENTS, 0, events per START; 0 = unlimited.
- CMD_START, 8'h73, start command byte ('s').
- CMD_STOP, 8'h6B, stop command byte ('k').
- EMPTY_MARK, 8'h45, byte sent when START finds the FIFO empty ('E').

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data_i  in  8  received command byte
- rx_valid_i  in  1  one-cycle strobe, rx_data_i valid
- fifo_dout_i  in  DATA_W  FIFO read data; valid the cycle after fifo_rd_en_o
- fifo_empty_i  in  1  FIFO empty flag
- fifo_rd_en_o  out  1  FIFO pop strobe
- tx_data_o  out  8  byte to UART TX
- tx_valid_o  out  1  tx_data_o valid
- tx_ready_i  in  1  UART TX accepts byte
- busy_o  out  1  high in any state other than IDLE
- events_sent_o  out  CNT_W  events fully transmitted since last START

Behaviour:
- Reset:
  - clk and reset are the only clock and reset. reset is synchronous and active-high.
  - At the edge where reset is high: state=IDLE; fifo_rd_en_o=0, tx_valid_o=0, tx_data_o=0, busy_o=0, events_sent_o=0, stop_pending=0.
  - Reset mid-transfer drops the partial event; no further bytes are sent.
- All outputs are registered.
- States: IDLE, POP, LOAD, SEND, CSUM, NEXT, MARK.
- IDLE:
  - rx_valid_i && rx_data_i==CMD_START:
    - Clear events_sent_o and stop_pending.
    - If fifo_empty_i, go to MARK; else go to POP.
  - All other bytes, including CMD_STOP, are ignored.
- POP: fifo_rd_en_o=1 for exactly this one cycle -> LOAD.
- LOAD:
  - Capture fifo_dout_i into the shift register; byte_idx=0.
  - Seed the checksum with 0 -> SEND.
- SEND:
  - tx_valid_o=1; tx_data_o = shreg[DATA_W-1 -: 8].
  - While tx_ready_i=0, tx_data_o is held stable and tx_valid_o stays high.
  - On a tx_valid_o && tx_ready_i edge: shift left 8, byte_idx++, checksum ^= byte.
  - After byte DATA_W/8-1 is accepted: go to CSUM if the feature is enabled, else NEXT.
- NEXT:
  - events_sent_o++, saturating at all-ones.
  - Go to IDLE if stop_pending, or fifo_empty_i, or (MAX_EVENTS!=0 && events_sent_o+1==MAX_EVENTS). Otherwise go to POP.
- MARK:
  - Send EMPTY_MARK once with the same handshake, then go to IDLE. events_sent_o stays 0.
- Commands while busy:
  - CMD_STOP received in any non-IDLE state sets stop_pending. The current event always completes; there is no truncation.
  - CMD_START while busy is ignored.
- Latency:
  - START sampled at edge 0 -> fifo_rd_en_o high in cycle 1 -> capture in cycle 2 -> tx_valid_o first high in cycle 3.
  - Between events there are 3 idle cycles (NEXT, POP, LOAD) with tx_valid_o=0.
- fifo_empty_i is sampled only in IDLE (on START) and in NEXT. fifo_rd_en_o is never asserted while fifo_empty_i=1 at decision time.

Optional Feature:
- Macro: EVT_CHECKSUM_EN.
- Defined: after the last data byte, state CSUM sends one extra byte equal to the XOR of all DATA_W/8 event bytes, with the same handshake, then goes to NEXT. Frame length is DATA_W/8+1.
- Undefined: the CSUM state and the checksum register are absent; frame length is DATA_W/8.

Test Plan:
- FIFO holds 64'h0011223344556677, then empty; rx 8'h73; tx_ready_i=1 -> rd_en pulses once in cycle 1; tx bytes 00,11,22,33,44,55,66,77 (+ checksum 8'h00 with EVT_CHECKSUM_EN); events_sent_o=1; busy_o falls.
- FIFO empty; rx 8'h73 -> single byte 8'h45; no rd_en; events_sent_o=0.
- FIFO holds 3 events; send 8'h6B during the 2nd event's 4th byte -> 2nd event completes all 8 bytes; no 3rd pop; events_sent_o=2.
- tx_ready_i toggles 1/0 every cycle -> each byte is held stable while tx_ready_i=0; the byte sequence is unchanged.
- MAX_EVENTS=2, FIFO holds 5 events -> exactly 2 pops, 16 bytes, return to IDLE; a second 8'h73 sends the next 2 events.
- Assert reset during the 3rd byte -> next cycle tx_valid_o=0, busy_o=0, events_sent_o=0; a following START restarts cleanly.
